mesi_cpu_req_fsm: RTL and testbench

Registered, multi-line successor to the combinational CPU-request MESI decoder. Holds the MESI state of `NUM_LINES` cache lines and sequences one CPU request at a time through hit handling, dirty write-back, bus request and bus response. It sits between the L1 CPU port and the shared snoop bus, using the `cache_rtl_def.sv` encodings for line state, `bus_req` and `bus_rsp`.

---
 rtl/mesi_cpu_req_fsm.sv | 202 ++++++++++++++++++++
 tb/tb_mesi_cpu_req_fsm.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_cpu_req_fsm.sv
// rtl/mesi_cpu_req_fsm.sv - registered multi-line CPU-request MESI controller (optional timeout: MESI_CPU_REQ_TIMEOUT_EN)
module mesi_cpu_req_fsm #(
    parameter int NUM_LINES   = 4,
    parameter int IDX_W       = $clog2(NUM_LINES),
    parameter int TIMEOUT_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req_vld,
    input  logic             cpu_req_wr,
    input  logic [IDX_W-1:0] cpu_req_idx,
    input  logic             cpu_req_hit,
    output logic             cpu_req_rdy,
    output logic             cpu_done,
    output logic             cpu_err,
    output logic             write_back,
    output logic [1:0]       bus_req,
    output logic [IDX_W-1:0] bus_req_idx,
    input  logic [1:0]       bus_rsp,
    input  logic             snp_inv_vld,
    input  logic [IDX_W-1:0] snp_inv_idx,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [3:0]       dbg_state
);

    // Line-state encodings (one-hot, shared with the rest of the cache RTL)
    localparam logic [3:0] LS_INVALID   = 4'b0001;
    localparam logic [3:0] LS_SHARED    = 4'b0010;
    localparam logic [3:0] LS_EXCLUSIVE = 4'b0100;
    localparam logic [3:0] LS_MODIFIED  = 4'b1000;

    localparam logic [1:0] BUS_NO_REQ         = 2'd0;
    localparam logic [1:0] BUS_READ_REQ       = 2'd1;
    localparam logic [1:0] BUS_RWITM_REQ      = 2'd2;
    localparam logic [1:0] BUS_INVALIDATE_REQ = 2'd3;

    localparam logic [1:0] BUS_SNOOP_FOUND_RSP = 2'd1;
    localparam logic [1:0] BUS_FETCH_MEM_RSP   = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        BUS  = 2'd2,
        DONE = 2'd3
    } ctrl_t;

    ctrl_t            state_q, state_d;
    logic [IDX_W-1:0] req_idx_q, req_idx_d;
    logic [1:0]       req_type_q, req_type_d;
    logic [3:0]       lines [NUM_LINES];
    logic [3:0]       ls;
    logic             rsp_vld;
    logic             line_we;
    logic [IDX_W-1:0] line_widx;
    logic [3:0]       line_wdata;
    logic             rdy_q, done_q, wb_q;
    logic [1:0]       bus_req_q;

`ifdef MESI_CPU_REQ_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    assign ls        = lines[cpu_req_idx];
    // 2'b11 is not a legal response and is treated as no response
    assign rsp_vld   = (bus_rsp == BUS_SNOOP_FOUND_RSP) || (bus_rsp == BUS_FETCH_MEM_RSP);
    assign dbg_state = lines[dbg_idx];

    // Next-state decode, request capture and line-update selection
    always_comb begin
        state_d    = state_q;
        req_idx_d  = req_idx_q;
        req_type_d = req_type_q;
        line_we    = 1'b0;
        line_widx  = req_idx_q;
        line_wdata = LS_INVALID;
`ifdef MESI_CPU_REQ_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req_vld) begin
                    req_idx_d = cpu_req_idx;
                    line_widx = cpu_req_idx;
                    if (cpu_req_hit && !cpu_req_wr &&
                        (ls == LS_EXCLUSIVE || ls == LS_MODIFIED || ls == LS_SHARED)) begin
                        state_d = DONE;
                    end else if (cpu_req_hit && cpu_req_wr &&
                                 (ls == LS_EXCLUSIVE || ls == LS_MODIFIED)) begin
                        line_we    = 1'b1;
                        line_wdata = LS_MODIFIED;
                        state_d    = DONE;
                    end else if (cpu_req_hit && cpu_req_wr && ls == LS_SHARED) begin
                        state_d = BUS;
                        // A snoop on the same edge already drops our copy, so an upgrade is no longer enough
                        req_type_d = (snp_inv_vld && snp_inv_idx == cpu_req_idx) ?
                                     BUS_RWITM_REQ : BUS_INVALIDATE_REQ;
                    end else begin
                        line_we    = 1'b1;
                        line_wdata = LS_INVALID;
                        req_type_d = cpu_req_wr ? BUS_RWITM_REQ : BUS_READ_REQ;
                        state_d    = (ls == LS_MODIFIED) ? WB : BUS;
                    end
                end
            end
            WB: begin
                state_d = BUS;
            end
            BUS: begin
                if (rsp_vld) begin
                    line_we = 1'b1;
                    if (req_type_q == BUS_READ_REQ)
                        line_wdata = (bus_rsp == BUS_SNOOP_FOUND_RSP) ? LS_SHARED : LS_EXCLUSIVE;
                    else
                        line_wdata = LS_MODIFIED;
                    state_d = DONE;
                end else begin
`ifdef MESI_CPU_REQ_TIMEOUT_EN
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                    if (snp_inv_vld && snp_inv_idx == req_idx_q &&
                        req_type_q == BUS_INVALIDATE_REQ)
                        req_type_d = BUS_RWITM_REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef MESI_CPU_REQ_TIMEOUT_EN
        if (state_q != BUS && state_d == BUS)
            cnt_d = 8'd0;
`endif
    end

    // Controller state, request registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_idx_q  <= '0;
            req_type_q <= BUS_NO_REQ;
            rdy_q      <= 1'b1;
            done_q     <= 1'b0;
            wb_q       <= 1'b0;
            bus_req_q  <= BUS_NO_REQ;
        end else begin
            state_q    <= state_d;
            req_idx_q  <= req_idx_d;
            req_type_q <= req_type_d;
            rdy_q      <= (state_d == IDLE);
            done_q     <= (state_d == DONE);
            wb_q       <= (state_d == WB);
            bus_req_q  <= (state_d == BUS) ? req_type_d : BUS_NO_REQ;
        end
    end

`ifdef MESI_CPU_REQ_TIMEOUT_EN
    // Bus-response timeout counter and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cpu_err = err_q;
`else
    assign cpu_err = 1'b0;
`endif

    // Line-state array; the CPU-side write is issued last so it wins over a same-line snoop
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++)
                lines[i] <= LS_INVALID;
        end else begin
            if (snp_inv_vld)
                lines[snp_inv_idx] <= LS_INVALID;
            if (line_we)
                lines[line_widx] <= line_wdata;
        end
    end

    assign cpu_req_rdy = rdy_q;
    assign cpu_done    = done_q;
    assign write_back  = wb_q;
    assign bus_req     = bus_req_q;
    assign bus_req_idx = req_idx_q;

endmodule

// File: tb/tb_mesi_cpu_req_fsm.sv
// tb/tb_mesi_cpu_req_fsm.sv - directed self-checking bench for mesi_cpu_req_fsm
module tb_mesi_cpu_req_fsm;

    localparam logic [3:0] I_ = 4'b0001;
    localparam logic [3:0] S_ = 4'b0010;
    localparam logic [3:0] E_ = 4'b0100;
    localparam logic [3:0] M_ = 4'b1000;
    localparam logic [1:0] NOREQ = 2'd0, RD = 2'd1, RWITM = 2'd2, INV = 2'd3;
    localparam logic [1:0] NORSP = 2'd0, SF = 2'd1, FM = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req_vld, cpu_req_wr, cpu_req_hit;
    logic [1:0] cpu_req_idx;
    logic       cpu_req_rdy, cpu_done, cpu_err, write_back;
    logic [1:0] bus_req, bus_req_idx, bus_rsp;
    logic       snp_inv_vld;
    logic [1:0] snp_inv_idx, dbg_idx;
    logic [3:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int hold;

    mesi_cpu_req_fsm #(.NUM_LINES(4), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req_vld(cpu_req_vld), .cpu_req_wr(cpu_req_wr),
        .cpu_req_idx(cpu_req_idx), .cpu_req_hit(cpu_req_hit),
        .cpu_req_rdy(cpu_req_rdy), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .write_back(write_back), .bus_req(bus_req), .bus_req_idx(bus_req_idx),
        .bus_rsp(bus_rsp), .snp_inv_vld(snp_inv_vld), .snp_inv_idx(snp_inv_idx),
        .dbg_idx(dbg_idx), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line_chk(input string tag, input logic [1:0] idx, input logic [3:0] exp);
        dbg_idx = idx;
        #1;
        chk(tag, {4'b0, dbg_state}, {4'b0, exp});
    endtask

    // Present one request for a single accept edge
    task automatic req(input logic wr, input logic [1:0] idx, input logic hit);
        cpu_req_vld = 1'b1; cpu_req_wr = wr; cpu_req_idx = idx; cpu_req_hit = hit;
        tick();
        cpu_req_vld = 1'b0; cpu_req_hit = 1'b0;
    endtask

    // Miss from a clean line answered immediately, ending back in IDLE
    task automatic fill(input logic wr, input logic [1:0] idx, input logic [1:0] rsp);
        req(wr, idx, 1'b0);
        bus_rsp = rsp;
        tick();
        bus_rsp = NORSP;
        tick();
    endtask

    initial begin
        rst = 1'b1; cpu_req_vld = 0; cpu_req_wr = 0; cpu_req_idx = 0; cpu_req_hit = 0;
        bus_rsp = NORSP; snp_inv_vld = 0; snp_inv_idx = 0; dbg_idx = 0;
        tick(); tick();
        chk("rst_rdy", {7'b0, cpu_req_rdy}, 8'd1);
        chk("rst_bus_req", {6'b0, bus_req}, {6'b0, NOREQ});
        chk("rst_bus_idx", {6'b0, bus_req_idx}, 8'd0);
        chk("rst_done", {7'b0, cpu_done}, 8'd0);
        chk("rst_wb", {7'b0, write_back}, 8'd0);
        for (int i = 0; i < 4; i++) line_chk("rst_line", 2'(i), I_);
        rst = 1'b0;
        bus_rsp = FM;        // ignored outside BUS
        tick();
        bus_rsp = NORSP;
        line_chk("rsp_idle_ignored", 2'd0, I_);

        // Read miss on idx 2, FETCH_MEM three cycles later
        req(1'b0, 2'd2, 1'b0);
        chk("rm_rdy", {7'b0, cpu_req_rdy}, 8'd0);
        chk("rm_req1", {6'b0, bus_req}, {6'b0, RD});
        chk("rm_idx", {6'b0, bus_req_idx}, 8'd2);
        tick();
        chk("rm_req2", {6'b0, bus_req}, {6'b0, RD});
        bus_rsp = 2'b11;     // illegal value, must not complete
        tick();
        chk("rm_req3", {6'b0, bus_req}, {6'b0, RD});
        bus_rsp = FM;
        tick();
        bus_rsp = NORSP;
        chk("rm_req_drop", {6'b0, bus_req}, {6'b0, NOREQ});
        chk("rm_done", {7'b0, cpu_done}, 8'd1);
        chk("rm_err", {7'b0, cpu_err}, 8'd0);
        line_chk("rm_line_e", 2'd2, E_);
        tick();
        chk("rm_done_1cyc", {7'b0, cpu_done}, 8'd0);
        chk("rm_rdy_back", {7'b0, cpu_req_rdy}, 8'd1);

        // Write hit on S line: invalidate upgrade
        fill(1'b0, 2'd1, SF);
        line_chk("s_fill", 2'd1, S_);
        req(1'b1, 2'd1, 1'b1);
        chk("wh_s_inv", {6'b0, bus_req}, {6'b0, INV});
        bus_rsp = SF;
        tick();
        bus_rsp = NORSP;
        chk("wh_s_done", {7'b0, cpu_done}, 8'd1);
        line_chk("wh_s_line_m", 2'd1, M_);
        tick();

        // Same upgrade with a snoop on the pending line: converted to RWITM
        fill(1'b0, 2'd0, SF);
        req(1'b1, 2'd0, 1'b1);
        chk("cv_inv", {6'b0, bus_req}, {6'b0, INV});
        snp_inv_vld = 1'b1; snp_inv_idx = 2'd0;
        tick();
        snp_inv_vld = 1'b0;
        chk("cv_rwitm", {6'b0, bus_req}, {6'b0, RWITM});
        line_chk("cv_line_i", 2'd0, I_);
        bus_rsp = FM;
        tick();
        bus_rsp = NORSP;
        line_chk("cv_line_m", 2'd0, M_);
        tick();

        // Write miss on M line idx 1: write-back first
        req(1'b1, 2'd1, 1'b0);
        chk("wbm_wb", {7'b0, write_back}, 8'd1);
        chk("wbm_noreq", {6'b0, bus_req}, {6'b0, NOREQ});
        chk("wbm_idx", {6'b0, bus_req_idx}, 8'd1);
        line_chk("wbm_line_i", 2'd1, I_);
        tick();
        chk("wbm_wb_1cyc", {7'b0, write_back}, 8'd0);
        chk("wbm_rwitm", {6'b0, bus_req}, {6'b0, RWITM});
        bus_rsp = SF;
        tick();
        bus_rsp = NORSP;
        chk("wbm_done", {7'b0, cpu_done}, 8'd1);
        line_chk("wbm_line_m", 2'd1, M_);
        tick();

        // Write hit on E idx 2: one-cycle hit latency
        req(1'b1, 2'd2, 1'b1);
        chk("hit_done", {7'b0, cpu_done}, 8'd1);
        chk("hit_rdy", {7'b0, cpu_req_rdy}, 8'd0);
        chk("hit_noreq", {6'b0, bus_req}, {6'b0, NOREQ});
        line_chk("hit_line_m", 2'd2, M_);
        tick();
        chk("hit_rdy_back", {7'b0, cpu_req_rdy}, 8'd1);
        req(1'b0, 2'd2, 1'b1);
        chk("rhit_done", {7'b0, cpu_done}, 8'd1);
        line_chk("rhit_line_m", 2'd2, M_);
        tick();

        // Snoop/fill collisions
        fill(1'b0, 2'd3, FM);
        line_chk("col_idx3_e", 2'd3, E_);
        req(1'b0, 2'd1, 1'b0);       // idx 1 is M: write-back then read
        chk("col_wb", {7'b0, write_back}, 8'd1);
        tick();
        chk("col_rd", {6'b0, bus_req}, {6'b0, RD});
        bus_rsp = FM; snp_inv_vld = 1'b1; snp_inv_idx = 2'd1;
        tick();
        bus_rsp = NORSP; snp_inv_vld = 1'b0;
        line_chk("col_same_e", 2'd1, E_);
        tick();
        req(1'b0, 2'd1, 1'b0);       // idx 1 now E: straight to bus
        bus_rsp = SF; snp_inv_vld = 1'b1; snp_inv_idx = 2'd3;
        tick();
        bus_rsp = NORSP; snp_inv_vld = 1'b0;
        line_chk("col_fill_s", 2'd1, S_);
        line_chk("col_other_i", 2'd3, I_);
        tick();

        // Reset in mid-operation
        req(1'b0, 2'd2, 1'b0);       // idx 2 is M: write-back
        chk("mid_wb", {7'b0, write_back}, 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_noreq", {6'b0, bus_req}, {6'b0, NOREQ});
        chk("mid_rdy", {7'b0, cpu_req_rdy}, 8'd1);
        chk("mid_wb_drop", {7'b0, write_back}, 8'd0);
        tick();
        chk("mid_no_done", {7'b0, cpu_done}, 8'd0);
        line_chk("mid_line_i", 2'd2, I_);

        // Bus response never arrives
        req(1'b0, 2'd0, 1'b0);
`ifdef MESI_CPU_REQ_TIMEOUT_EN
        hold = 0;
        for (int i = 0; i < 10 && bus_req == RD; i++) begin
            hold++;
            tick();
        end
        chk("to_bus_cycles", 8'(hold), 8'd4);
        chk("to_done", {7'b0, cpu_done}, 8'd1);
        chk("to_err", {7'b0, cpu_err}, 8'd1);
        line_chk("to_line_i", 2'd0, I_);
        tick();
        chk("to_err_1cyc", {7'b0, cpu_err}, 8'd0);
`else
        hold = 0;
        for (int i = 0; i < 100; i++) begin
            bus_rsp = (i % 7 == 3) ? 2'b11 : NORSP;
            if (bus_req == RD && !cpu_done) hold++;
            tick();
        end
        bus_rsp = NORSP;
        chk("nto_hold", 8'(hold), 8'd100);
        chk("nto_still_rd", {6'b0, bus_req}, {6'b0, RD});
        bus_rsp = FM;
        tick();
        bus_rsp = NORSP;
        chk("nto_done", {7'b0, cpu_done}, 8'd1);
        chk("nto_err", {7'b0, cpu_err}, 8'd0);
        line_chk("nto_line_e", 2'd0, E_);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
